arb_param_rr: RTL and testbench

- Parametrised N-way request/grant arbiter.
- Provides fixed-priority mode, where index 0 is highest priority, and round-robin mode.
- The owner keeps the grant while it holds its request (lock). An optional hold limit forces re-arbitration after a set number of cycles.
- Sits in front of any shared resource (bus, memory port, FIFO write side). It replaces hard-wired 2-requester arbiters.

---
 rtl/arb_param_rr.sv | 143 ++++++++++++++
 tb/tb_arb_param_rr.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/arb_param_rr.sv
// ---------------------------------------------------------------------------
// arb_param_rr
// Parametrised N-way request/grant arbiter with lock-on-hold and an optional
// hold limit. MODE=0 gives fixed priority (index 0 highest), MODE=1 gives
// round-robin starting from a rotating pointer. All outputs are registered,
// so a request sampled on one edge is reflected in the grant after that edge.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         synchronous active-low reset (0 = reset)
//   request_i      [N-1:0] per-requester request, bit i = requester i
//   grant_o        [N-1:0] registered one-hot grant, or all zeros
//   grant_id_o     [$clog2(N)-1:0] index of granted requester, 0 when idle
//   grant_valid_o  high when any grant bit is set
// ---------------------------------------------------------------------------
module arb_param_rr #(
  parameter int N        = 4,
  parameter int MODE     = 0,
  parameter int HOLD_MAX = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N-1:0]           request_i,
  output logic [N-1:0]           grant_o,
  output logic [$clog2(N)-1:0]   grant_id_o,
  output logic                   grant_valid_o
);

  localparam int IW = $clog2(N);
  localparam int HW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HLIM = (HOLD_MAX > 0) ? HW'(HOLD_MAX - 1) : '0;
  localparam logic [HW-1:0] HSAT = '1;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  ptr_q,   ptr_d;
  logic [HW-1:0]  hcnt_q,  hcnt_d;
  logic [N-1:0]   grant_q, grant_d;

  // Scan req starting at index 'start', wrapping at N. Returns {found, index}.
  function automatic logic [IW:0] arb_pick(input logic [N-1:0]  req,
                                           input logic [IW-1:0] start);
    logic          found;
    logic [IW-1:0] win;
    int            idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    return {found, win};
  endfunction

  // Hold counter saturates instead of wrapping so an unlimited hold never
  // looks like a fresh grant.
  function automatic logic [HW-1:0] hcnt_sat_inc(input logic [HW-1:0] h);
    return (h == HSAT) ? h : h + HW'(1);
  endfunction

  function automatic logic [IW-1:0] idx_next(input logic [IW-1:0] j);
    return IW'((int'(j) + 1) % N);
  endfunction

  logic           owner_req;
  logic           keep;
  logic           expire;
  logic [N-1:0]   arb_req;
  logic [IW:0]    pick;
  logic [IW-1:0]  arb_start;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    grant_d   = grant_q;
    owner_req = request_i[owner_q];
    keep      = 1'b0;
    expire    = 1'b0;
    arb_req   = request_i;
    arb_start = (MODE == 1) ? ptr_q : '0;

    if (state_q == OWNED && owner_req) begin
      if (HOLD_MAX == 0 || hcnt_q < HLIM) begin
        keep = 1'b1;
      end else begin
        expire = 1'b1;
      end
    end

    // On expiry the owner steps aside so anyone else waiting gets a turn.
    if (expire) begin
      arb_req = request_i & ~({{(N-1){1'b0}}, 1'b1} << owner_q);
    end
    pick = arb_pick(arb_req, arb_start);

    if (keep) begin
      hcnt_d = hcnt_sat_inc(hcnt_q);
    end else if (pick[IW]) begin
      state_d = OWNED;
      owner_d = pick[IW-1:0];
      grant_d = {{(N-1){1'b0}}, 1'b1} << pick[IW-1:0];
      hcnt_d  = '0;
      if (MODE == 1) begin
        ptr_d = idx_next(pick[IW-1:0]);
      end
    end else if (expire) begin
      // Nobody else wants the resource: owner keeps it with a fresh count.
      hcnt_d = '0;
    end else begin
      state_d = IDLE;
      owner_d = '0;
      grant_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hcnt_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_id_o    = owner_q;
  assign grant_valid_o = (state_q == OWNED);

endmodule

// File: tb/tb_arb_param_rr.sv
module tb_arb_param_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // fp: fixed priority, unlimited hold
  logic       rst_fp = 1'b0;
  logic [3:0] req_fp = '0, gnt_fp;
  logic [1:0] id_fp;
  logic       vld_fp;
  // rr1: round-robin, hold limit 1
  logic       rst_rr1 = 1'b0;
  logic [3:0] req_rr1 = '0, gnt_rr1;
  logic [1:0] id_rr1;
  logic       vld_rr1;
  // hx: fixed priority, hold limit 3
  logic       rst_hx = 1'b0;
  logic [3:0] req_hx = '0, gnt_hx;
  logic [1:0] id_hx;
  logic       vld_hx;
  // rr0: round-robin, unlimited hold
  logic       rst_rr0 = 1'b0;
  logic [3:0] req_rr0 = '0, gnt_rr0;
  logic [1:0] id_rr0;
  logic       vld_rr0;
  // n3: three requesters, round-robin, hold limit 1
  logic       rst_n3 = 1'b0;
  logic [2:0] req_n3 = '0, gnt_n3;
  logic [1:0] id_n3;
  logic       vld_n3;

  arb_param_rr #(.N(4), .MODE(0), .HOLD_MAX(0)) u_fp (
    .clk_i(clk), .rst_ni(rst_fp), .request_i(req_fp),
    .grant_o(gnt_fp), .grant_id_o(id_fp), .grant_valid_o(vld_fp));
  arb_param_rr #(.N(4), .MODE(1), .HOLD_MAX(1)) u_rr1 (
    .clk_i(clk), .rst_ni(rst_rr1), .request_i(req_rr1),
    .grant_o(gnt_rr1), .grant_id_o(id_rr1), .grant_valid_o(vld_rr1));
  arb_param_rr #(.N(4), .MODE(0), .HOLD_MAX(3)) u_hx (
    .clk_i(clk), .rst_ni(rst_hx), .request_i(req_hx),
    .grant_o(gnt_hx), .grant_id_o(id_hx), .grant_valid_o(vld_hx));
  arb_param_rr #(.N(4), .MODE(1), .HOLD_MAX(0)) u_rr0 (
    .clk_i(clk), .rst_ni(rst_rr0), .request_i(req_rr0),
    .grant_o(gnt_rr0), .grant_id_o(id_rr0), .grant_valid_o(vld_rr0));
  arb_param_rr #(.N(3), .MODE(1), .HOLD_MAX(1)) u_n3 (
    .clk_i(clk), .rst_ni(rst_n3), .request_i(req_n3),
    .grant_o(gnt_n3), .grant_id_o(id_n3), .grant_valid_o(vld_n3));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp4;
  logic [2:0] exp3;

  initial begin
    // Reset dominance: all units held in reset, fp sees all requests.
    req_fp = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_grant", gnt_fp, 4'b0000);
      chk("rst_id",    id_fp,  0);
      chk("rst_vld",   vld_fp, 0);
    end
    rst_fp = 1'b1; rst_rr1 = 1'b1; rst_hx = 1'b1; rst_rr0 = 1'b1; rst_n3 = 1'b1;
    tick();
    chk("rst_rel_grant", gnt_fp, 4'b0001);
    chk("rst_rel_vld",   vld_fp, 1);

    // Fixed priority and one-cycle latency.
    req_fp = 4'b1010;
    tick();
    chk("fp_grant", gnt_fp, 4'b0010);
    chk("fp_id",    id_fp,  1);
    req_fp = 4'b1000;
    tick();
    chk("fp_grant3", gnt_fp, 4'b1000);
    chk("fp_id3",    id_fp,  3);

    // Lock: requester 1 keeps the grant although 0 asks from cycle 2.
    req_fp = 4'b0010;
    tick();
    chk("lock_c1", gnt_fp, 4'b0010);
    req_fp = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lock_hold", gnt_fp, 4'b0010);
    end
    req_fp = 4'b0001;
    tick();
    chk("lock_release", gnt_fp, 4'b0001);
    chk("lock_rel_id",  id_fp,  0);
    req_fp = 4'b0000;
    tick();
    chk("idle_grant", gnt_fp, 4'b0000);
    chk("idle_vld",   vld_fp, 0);
    chk("idle_id",    id_fp,  0);

    // Round-robin rotation with hold limit 1.
    req_rr1 = 4'b1111;
    exp4 = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_rot", gnt_rr1, exp4);
      chk("rr_rot_id", id_rr1, i % 4);
      exp4 = {exp4[2:0], exp4[3]};
    end

    // Hold expiry: 3 cycles each, alternating.
    req_hx = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("hx_alt", gnt_hx, ((i / 3) % 2 == 0) ? 4'b0001 : 4'b0010);
    end
    req_hx = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hx_solo", gnt_hx, 4'b0001);
      chk("hx_solo_vld", vld_hx, 1);
    end

    // Mid-operation reset: owner 2 with ptr 3, then reset.
    req_rr0 = 4'b0100;
    tick();
    chk("mr_own2", gnt_rr0, 4'b0100);
    req_rr0 = 4'b0110;
    tick();
    chk("mr_lock", gnt_rr0, 4'b0100);
    rst_rr0 = 1'b0;
    tick();
    chk("mr_rst_grant", gnt_rr0, 4'b0000);
    chk("mr_rst_vld",   vld_rr0, 0);
    rst_rr0 = 1'b1;
    tick();
    chk("mr_after", gnt_rr0, 4'b0010);
    chk("mr_after_id", id_rr0, 1);
    // Owner 1 drops, 2 wins from ptr 2; a reset then must return ptr to 0.
    req_rr0 = 4'b0100;
    tick();
    chk("mr_own2b", gnt_rr0, 4'b0100);
    req_rr0 = 4'b1001;
    rst_rr0 = 1'b0;
    tick();
    chk("mr_rst2", gnt_rr0, 4'b0000);
    rst_rr0 = 1'b1;
    tick();
    chk("mr_ptr0", gnt_rr0, 4'b0001);

    // Non-power-of-two wrap.
    req_n3 = 3'b111;
    exp3 = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("n3_rot", gnt_n3, exp3);
      chk("n3_id",  id_n3,  i % 3);
      exp3 = {exp3[1:0], exp3[2]};
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
